// File: rtl/gemm_store_controller.sv
// gemm_store_controller
//
// STORE phase of the GEMM load/execute controller. On the first can_store
// cycle the C-tile descriptor is captured, the controller waits DRAIN_CYCLES
// for the systolic array to drain, then writes msize rows from the
// accumulator to memory, one row per accepted handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   can_store                start request from the load/execute controller
//   tile_C_addr/stride       C tile row-0 address and row pitch (bytes)
//   msize, nsize             rows to store, row length in elements
//   accum_ready              accumulator has a result row available
//   accum_rd_en              pop one accumulator row
//   gen_addr_store           load next_row_addr_store into the address gen
//   next_row_addr_store      row address for the address generator
//   interface_en_store       memory interface request
//   interface_rdwr_store     1 = write
//   interface_control_store  transfer length (captured nsize)
//   done_store               last row written this cycle
//   busy                     controller not idle
module gemm_store_controller #(
    parameter int DRAIN_CYCLES = 16,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [4:0]        msize,
    input  logic [4:0]        nsize,
    input  logic              accum_ready,
    output logic              accum_rd_en,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic              interface_rdwr_store,
    output logic [4:0]        interface_control_store,
    output logic              done_store,
    output logic              busy
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // Terminal drain count; unused when there is no drain phase.
    localparam int DRAIN_LAST_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          msize_q, msize_d;
    logic [4:0]          nsize_q, nsize_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [4:0]          row_cnt_q, row_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]   next_addr;

    // Address of the following row; wraps modulo 2^ADDR_W.
    assign next_addr = row_addr_q + stride_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            msize_q     <= '0;
            nsize_q     <= '0;
            stride_q    <= '0;
            row_addr_q  <= '0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            msize_q     <= msize_d;
            nsize_q     <= nsize_d;
            stride_q    <= stride_d;
            row_addr_q  <= row_addr_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        msize_d     = msize_q;
        nsize_d     = nsize_q;
        stride_d    = stride_q;
        row_addr_d  = row_addr_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;

        accum_rd_en             = 1'b0;
        gen_addr_store          = 1'b0;
        next_row_addr_store     = row_addr_q;
        interface_en_store      = 1'b0;
        interface_rdwr_store    = 1'b0;
        interface_control_store = 5'd0;
        done_store              = 1'b0;
        busy                    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (can_store) begin
                    // Zero-latency preload: the upstream controller forwards
                    // this address to the generator in the start cycle.
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = tile_C_addr;
                    msize_d             = msize;
                    nsize_d             = nsize;
                    stride_d            = tile_C_stride;
                    row_addr_d          = tile_C_addr;
                    row_cnt_d           = 5'd0;
                    drain_cnt_d         = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (msize_q == 5'd0) begin
                    // Empty tile: finish immediately without touching memory.
                    done_store = 1'b1;
                    state_d    = S_IDLE;
                end else if (accum_ready) begin
                    accum_rd_en             = 1'b1;
                    interface_en_store      = 1'b1;
                    interface_rdwr_store    = 1'b1;
                    interface_control_store = nsize_q;
                    if (row_cnt_q == msize_q - 5'd1) begin
                        done_store = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        // Preload the generator for the row after this one.
                        row_cnt_d           = row_cnt_q + 5'd1;
                        row_addr_d          = next_addr;
                        gen_addr_store      = 1'b1;
                        next_row_addr_store = next_addr;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset blanks every output in the same cycle it is asserted.
        if (!rst) begin
            accum_rd_en             = 1'b0;
            gen_addr_store          = 1'b0;
            next_row_addr_store     = '0;
            interface_en_store      = 1'b0;
            interface_rdwr_store    = 1'b0;
            interface_control_store = 5'd0;
            done_store              = 1'b0;
            busy                    = 1'b0;
        end
    end

endmodule

// File: doc/gemm_store_controller.md
Name: gemm_store_controller

Overview:
- Drives the STORE phase of the GEMM load/execute controller.
- On the first can_store cycle it captures the C-tile descriptor and waits a fixed systolic drain interval.
- It then writes msize result rows from the accumulator to memory, one row per handshake, through the shared memory interface.
- It generates the *_store interface/address-generator signals and done_store, which the load/execute controller muxes onto the bus while in STORE.

Parameters:
DRAIN_CYCLES, 16, cycles between store start and first row write (systolic array drain latency); 0 allowed
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset
can_store  in  1  from load/execute controller; high from the start-of-store cycle until the done cycle
tile_C_addr  in  ADDR_W  base address of C tile row 0
tile_C_stride  in  ADDR_W  byte distance between consecutive C rows
msize  in  5  number of rows to store
nsize  in  5  row length (elements) passed as interface control
accum_ready  in  1  accumulator has the next result row available
accum_rd_en  out  1  pop one row from the accumulator
gen_addr_store  out  1  load next_row_addr_store into the address generator
next_row_addr_store  out  ADDR_W  row address to load
interface_en_store  out  1  memory interface request
interface_rdwr_store  out  1  1 = write
interface_control_store  out  5  transfer length (= captured nsize)
done_store  out  1  last row written this cycle
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- While rst is low: state <= IDLE, all counters and registers <= 0, and every output is forced to 0 combinationally.
- Outputs are combinational from state and registers. Defaults are 0; next_row_addr_store defaults to row_addr_q.
- Capture registers: msize_q, nsize_q, stride_q, row_addr_q (ADDR_W), row_cnt (5 b), drain_cnt (wide enough for DRAIN_CYCLES).
- IDLE:
  - If can_store: gen_addr_store=1 and next_row_addr_store=tile_C_addr in the same cycle (zero latency; the upstream controller uses these in that cycle).
  - Register msize, nsize, stride. Set row_addr_q <= tile_C_addr, row_cnt <= 0, drain_cnt <= 0.
  - Go to DRAIN, or to WRITE if DRAIN_CYCLES == 0.
- DRAIN:
  - No outputs except busy. drain_cnt increments each cycle.
  - When drain_cnt == DRAIN_CYCLES-1, go to WRITE.
- WRITE with msize_q == 0:
  - done_store=1 on the first WRITE cycle regardless of accum_ready.
  - No accum_rd_en and no interface_en_store. Go to IDLE.
- WRITE with accum_ready=0:
  - Stall. All outputs 0 except busy. Registers hold.
- WRITE with accum_ready=1:
  - accum_rd_en=1, interface_en_store=1, interface_rdwr_store=1, interface_control_store=nsize_q.
  - If row_cnt != msize_q-1: row_cnt++, row_addr_q <= row_addr_q + stride_q. gen_addr_store=1 with next_row_addr_store = row_addr_q + stride_q, so the generator is preloaded for the next row.
  - If row_cnt == msize_q-1: done_store=1, gen_addr_store=0, go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- can_store is ignored outside IDLE. Tile inputs are sampled only on the IDLE start cycle; later changes have no effect.
- can_store low mid-operation (outside IDLE) does not abort the store; only rst aborts.
- done_store is high for exactly one cycle per store. The block is back in IDLE the following cycle and can accept a new can_store immediately.
- accum_rd_en and interface_en_store are always asserted together; write count = msize_q exactly.

Test Plan:
- Basic store: DRAIN_CYCLES=4, tile_C_addr=0x1000, stride=0x40, msize=3, nsize=8, accum_ready=1 -> start cycle gen=1/addr=0x1000; 4 drain cycles; writes on 3 consecutive cycles; gen_addr_store addresses 0x1040, 0x1080 on writes 1–2; done_store with write 3; control=8, rdwr=1 on every write.
- Backpressure: same stimulus, accum_ready toggling 1,0,0,1,1 -> writes only on ready cycles; no address change during stalls; done_store on the 3rd accepted write.
- Zero rows / zero drain: DRAIN_CYCLES=0, msize=0 -> start cycle gen=1; next cycle done_store=1 with interface_en_store=0; busy low after.
- Wrap: tile_C_addr=0xFFFF_FFC0, stride=0x40, msize=2 -> second row address 0x0000_0000.
- Reset mid-store: rst low during write 2 of msize=5 -> all outputs 0 that cycle; IDLE afterwards; a new can_store restarts cleanly at row 0 with the new tile_C_addr.
- Back-to-back: can_store reasserted the cycle after done_store with a new base 0x2000 -> new store accepted immediately; first address 0x2000; the old descriptor is not reused.
